// File: rtl/cceip_outbound_pkg.sv
// Shared constants, state encoding and helpers for the CCEIP egress framer.
package cceip_outbound_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned USER_W = 8;
    localparam int unsigned SKID_W = DATA_W + 1;
    localparam int unsigned ERR_W  = 3;

    localparam int unsigned TUSER_SOT = 0;
    localparam int unsigned TUSER_EOT = 1;

    localparam logic [1:0] FT_DATA   = 2'b01;
    localparam logic [1:0] FT_STATUS = 2'b11;

    localparam int unsigned ERR_BAD_TYPE = 0;
    localparam int unsigned ERR_STRB     = 1;
    localparam int unsigned ERR_OVERFLOW = 2;

    typedef enum logic [2:0] {
        s_idle, s_header, s_data, s_status, s_drop, s_drain, s_done
    } state_e;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } mm_beat_t;

    function automatic logic [3:0] popcount8(input logic [STRB_W-1:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < int'(STRB_W); i++) sum = sum + 4'(v[i]);
        return sum;
    endfunction

endpackage

// File: rtl/cceip_outbound_skid.sv
// Two-entry skid buffer: upstream ready and downstream valid/data come straight from flops.
module cceip_outbound_skid
    import cceip_outbound_pkg::*;
(
    input  logic              ap_clk,
    input  logic              areset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [SKID_W-1:0] s_beat,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [SKID_W-1:0] m_beat,
    output logic              empty
);

    logic              skid_valid;
    logic [SKID_W-1:0] skid_beat;
    logic              push;

    // Ready depends only on the skid flop, so downstream stalls never reach upstream combinationally.
    assign s_ready = ~skid_valid;
    assign push    = s_valid & s_ready;
    assign empty   = ~m_valid & ~skid_valid;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            m_valid    <= 1'b0;
            m_beat     <= '0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
        end else if (!m_valid || m_ready) begin
            if (skid_valid) begin
                m_beat     <= skid_beat;
                m_valid    <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                m_valid <= push;
                if (push) m_beat <= s_beat;
            end
        end else if (push) begin
            skid_beat  <= s_beat;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/cceip_outbound.sv
// CCEIP egress framer: strips frame headers, forwards data payload to the write mover,
// captures the status word and reports byte count and error flags at job end.
module cceip_outbound
    import cceip_outbound_pkg::*;
(
    input  logic              ap_clk,
    input  logic              areset,
    input  logic              outbound_start,
    output logic              outbound_done,
    input  logic [DATA_W-1:0] output_buffer_size,
    output logic [DATA_W-1:0] output_data_size,
    output logic [DATA_W-1:0] status_word,
    output logic [ERR_W-1:0]  error_flags,
    input  logic              cceip_s_axis_tvalid,
    output logic              cceip_s_axis_tready,
    input  logic              cceip_s_axis_tlast,
    input  logic [STRB_W-1:0] cceip_s_axis_tstrb,
    input  logic [USER_W-1:0] cceip_s_axis_tuser,
    input  logic              cceip_s_axis_tid,
    input  logic [DATA_W-1:0] cceip_s_axis_tdata,
    output logic              mm_m_axis_tvalid,
    input  logic              mm_m_axis_tready,
    output logic              mm_m_axis_tlast,
    output logic [DATA_W-1:0] mm_m_axis_tdata
);

    state_e            state, state_nx;
    logic [DATA_W-1:0] buf_size, buf_size_nx;
    logic [DATA_W-1:0] cnt_nx, status_nx, byte_sum;
    logic [ERR_W-1:0]  flags_nx;
    logic              status_seen, status_seen_nx;
    logic              accept, push, skid_ready, skid_empty;
    logic              sot, eot;
    mm_beat_t          beat_in, beat_out;
    logic              unused_inputs;

    assign unused_inputs = ^{cceip_s_axis_tid, cceip_s_axis_tuser[USER_W-1:2]};

    assign sot      = cceip_s_axis_tuser[TUSER_SOT];
    assign eot      = cceip_s_axis_tuser[TUSER_EOT];
    assign byte_sum = output_data_size + 64'(popcount8(cceip_s_axis_tstrb));
    assign beat_in  = '{last: eot | cceip_s_axis_tlast, data: cceip_s_axis_tdata};

    always_comb begin
        state_nx       = state;
        buf_size_nx    = buf_size;
        cnt_nx         = output_data_size;
        status_nx      = status_word;
        status_seen_nx = status_seen;
        flags_nx       = error_flags;
        push           = 1'b0;

        case (state)
            s_header, s_status, s_drop: cceip_s_axis_tready = 1'b1;
            s_data:                     cceip_s_axis_tready = skid_ready;
            default:                    cceip_s_axis_tready = 1'b0;
        endcase
        accept = cceip_s_axis_tvalid & cceip_s_axis_tready;

        case (state)
            s_idle: begin
                if (outbound_start) begin
                    buf_size_nx    = output_buffer_size;
                    cnt_nx         = '0;
                    status_nx      = '0;
                    status_seen_nx = 1'b0;
                    flags_nx       = '0;
                    state_nx       = s_header;
                end
            end
            s_header: begin
                if (accept) begin
                    if (!sot) begin
                        flags_nx[ERR_BAD_TYPE] = 1'b1;
                    end else if (cceip_s_axis_tdata[63:62] == FT_DATA) begin
                        state_nx = s_data;
                    end else if (cceip_s_axis_tdata[63:62] == FT_STATUS) begin
                        state_nx = s_status;
                    end else begin
                        flags_nx[ERR_BAD_TYPE] = 1'b1;
                        state_nx               = s_drop;
                    end
                end
            end
            s_data: begin
                if (accept) begin
                    cnt_nx = byte_sum;
                    if (!eot && cceip_s_axis_tstrb != 8'hff) flags_nx[ERR_STRB] = 1'b1;
                    // Words past the destination capacity are consumed but never forwarded.
                    if (byte_sum > buf_size) flags_nx[ERR_OVERFLOW] = 1'b1;
                    else                     push = 1'b1;
                    if (eot) state_nx = s_header;
                end
            end
            s_status: begin
                if (accept) begin
                    if (!status_seen) begin
                        status_nx      = cceip_s_axis_tdata;
                        status_seen_nx = 1'b1;
                    end
                    if (eot) state_nx = s_header;
                end
            end
            s_drop: begin
                if (accept && eot) state_nx = s_header;
            end
            s_drain: begin
                if (skid_empty) state_nx = s_done;
            end
            s_done:  state_nx = s_idle;
            default: state_nx = s_idle;
        endcase

        // Stream tlast ends the job regardless of frame position.
        if (accept && cceip_s_axis_tlast) state_nx = s_drain;
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state            <= s_idle;
            buf_size         <= '0;
            output_data_size <= '0;
            status_word      <= '0;
            status_seen      <= 1'b0;
            error_flags      <= '0;
            outbound_done    <= 1'b0;
        end else begin
            state            <= state_nx;
            buf_size         <= buf_size_nx;
            output_data_size <= cnt_nx;
            status_word      <= status_nx;
            status_seen      <= status_seen_nx;
            error_flags      <= flags_nx;
            outbound_done    <= (state_nx == s_done);
        end
    end

    cceip_outbound_skid u_skid (
        .ap_clk  (ap_clk),
        .areset  (areset),
        .s_valid (push),
        .s_ready (skid_ready),
        .s_beat  (beat_in),
        .m_valid (mm_m_axis_tvalid),
        .m_ready (mm_m_axis_tready),
        .m_beat  (beat_out),
        .empty   (skid_empty)
    );

    assign mm_m_axis_tlast = beat_out.last;
    assign mm_m_axis_tdata = beat_out.data;

endmodule

// File: tb/tb_cceip_outbound.sv
// Directed bench for the CCEIP egress framer.
module tb_cceip_outbound;
    import cceip_outbound_pkg::*;

    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        outbound_start = 1'b0;
    logic        outbound_done;
    logic [63:0] output_buffer_size = '0;
    logic [63:0] output_data_size;
    logic [63:0] status_word;
    logic [2:0]  error_flags;
    logic        cceip_s_axis_tvalid = 1'b0;
    logic        cceip_s_axis_tready;
    logic        cceip_s_axis_tlast = 1'b0;
    logic [7:0]  cceip_s_axis_tstrb = '0;
    logic [7:0]  cceip_s_axis_tuser = '0;
    logic        cceip_s_axis_tid = 1'b0;
    logic [63:0] cceip_s_axis_tdata = '0;
    logic        mm_m_axis_tvalid;
    logic        mm_m_axis_tready = 1'b1;
    logic        mm_m_axis_tlast;
    logic [63:0] mm_m_axis_tdata;

    cceip_outbound dut (
        .ap_clk(ap_clk), .areset(areset),
        .outbound_start(outbound_start), .outbound_done(outbound_done),
        .output_buffer_size(output_buffer_size), .output_data_size(output_data_size),
        .status_word(status_word), .error_flags(error_flags),
        .cceip_s_axis_tvalid(cceip_s_axis_tvalid), .cceip_s_axis_tready(cceip_s_axis_tready),
        .cceip_s_axis_tlast(cceip_s_axis_tlast), .cceip_s_axis_tstrb(cceip_s_axis_tstrb),
        .cceip_s_axis_tuser(cceip_s_axis_tuser), .cceip_s_axis_tid(cceip_s_axis_tid),
        .cceip_s_axis_tdata(cceip_s_axis_tdata),
        .mm_m_axis_tvalid(mm_m_axis_tvalid), .mm_m_axis_tready(mm_m_axis_tready),
        .mm_m_axis_tlast(mm_m_axis_tlast), .mm_m_axis_tdata(mm_m_axis_tdata)
    );

    always #5 ap_clk = ~ap_clk;

    localparam logic [63:0] HDR_DATA   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] HDR_STATUS = 64'hC000_0000_0000_0000;
    localparam logic [63:0] HDR_BAD    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] D0 = 64'hA0A0_1111_0000_0001;
    localparam logic [63:0] D1 = 64'hB1B1_2222_0000_0002;
    localparam logic [63:0] D2 = 64'hC2C2_3333_0000_0003;
    localparam logic [63:0] D3 = 64'hD3D3_4444_0000_0004;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          full_viol = 0;
    bit          toggle_mode = 1'b0;
    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge ap_clk) begin
        if (mm_m_axis_tvalid && mm_m_axis_tready) got_q.push_back({mm_m_axis_tlast, mm_m_axis_tdata});
        if (outbound_done) done_cnt++;
    end

    always @(negedge ap_clk)
        if (cceip_s_axis_tready && dut.state == s_data && dut.u_skid.skid_valid) full_viol++;

    initial begin
        forever begin
            @(negedge ap_clk);
            mm_m_axis_tready = toggle_mode ? ~mm_m_axis_tready : 1'b1;
        end
    end

    task automatic send(input logic [63:0] d, input logic [7:0] strb, input logic [7:0] user,
                        input logic last);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        cceip_s_axis_tvalid = 1'b1;
        cceip_s_axis_tdata  = d;
        cceip_s_axis_tstrb  = strb;
        cceip_s_axis_tuser  = user;
        cceip_s_axis_tlast  = last;
        while (!ok && n < 200) begin
            @(negedge ap_clk);
            if (cceip_s_axis_tready) ok = 1'b1;
            n++;
        end
        if (ok) begin
            @(posedge ap_clk);
            #1;
        end else begin
            check("send_timeout", 64'd0, 64'd1);
        end
        cceip_s_axis_tvalid = 1'b0;
        cceip_s_axis_tlast  = 1'b0;
    endtask

    task automatic start_job(input logic [63:0] bsize);
        @(negedge ap_clk);
        output_buffer_size = bsize;
        outbound_start     = 1'b1;
        @(posedge ap_clk);
        #1;
        outbound_start = 1'b0;
    endtask

    task automatic finish_job(input string name, input int base, input logic [63:0] exp_size,
                              input logic [63:0] exp_status, input logic [2:0] exp_flags,
                              input int exp_done);
        int n;
        n = 0;
        while (!outbound_done && n < 1000) begin
            @(negedge ap_clk);
            n++;
        end
        check({name, "_done_seen"}, 64'(outbound_done), 64'd1);
        check({name, "_size"}, output_data_size, exp_size);
        check({name, "_status"}, status_word, exp_status);
        check({name, "_flags"}, 64'(error_flags), 64'(exp_flags));
        @(negedge ap_clk);
        check({name, "_done_pulse"}, 64'(outbound_done), 64'd0);
        check({name, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
        check({name, "_mm_len"}, 64'(got_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                check({name, "_mm_data"}, got_q[base+i][63:0], exp_q[i][63:0]);
                check({name, "_mm_last"}, 64'(got_q[base+i][64]), 64'(exp_q[i][64]));
            end
        end
        exp_q.delete();
    endtask

    // Data frame (3 full words + 4-byte EoT word) followed by a status frame ending the job.
    task automatic std_job();
        start_job(64'd1024);
        send(HDR_DATA, 8'hff, 8'h01, 1'b0);
        send(D0, 8'hff, 8'h00, 1'b0);
        send(D1, 8'hff, 8'h00, 1'b0);
        send(D2, 8'hff, 8'h00, 1'b0);
        send(D3, 8'h0f, 8'h02, 1'b0);
        send(HDR_STATUS, 8'hff, 8'h01, 1'b0);
        send(64'hDEAD_BEEF, 8'hff, 8'h02, 1'b1);
        exp_q.push_back({1'b0, D0});
        exp_q.push_back({1'b0, D1});
        exp_q.push_back({1'b0, D2});
        exp_q.push_back({1'b1, D3});
    endtask

    initial begin
        int base;
        repeat (3) @(posedge ap_clk);
        #1 areset = 1'b0;
        @(negedge ap_clk);
        check("rst_tready", 64'(cceip_s_axis_tready), 64'd0);
        check("rst_mm_valid", 64'(mm_m_axis_tvalid), 64'd0);
        check("rst_size", output_data_size, 64'd0);
        check("rst_flags", 64'(error_flags), 64'd0);
        check("rst_done", 64'(outbound_done), 64'd0);

        base = got_q.size();
        std_job();
        finish_job("basic", base, 64'd28, 64'hDEAD_BEEF, 3'b000, 1);

        toggle_mode = 1'b1;
        base = got_q.size();
        std_job();
        finish_job("bp", base, 64'd28, 64'hDEAD_BEEF, 3'b000, 2);
        toggle_mode = 1'b0;
        check("bp_tready_full", 64'(full_viol), 64'd0);

        base = got_q.size();
        start_job(64'd16);
        send(HDR_DATA, 8'hff, 8'h01, 1'b0);
        send(D0, 8'hff, 8'h00, 1'b0);
        send(D1, 8'hff, 8'h00, 1'b0);
        send(D2, 8'hff, 8'h00, 1'b0);
        send(D3, 8'hff, 8'h02, 1'b1);
        exp_q.push_back({1'b0, D0});
        exp_q.push_back({1'b0, D1});
        finish_job("ovf", base, 64'd32, 64'd0, 3'b100, 3);

        base = got_q.size();
        start_job(64'd1024);
        send(HDR_DATA, 8'hff, 8'h01, 1'b0);
        send(D0, 8'hff, 8'h00, 1'b0);
        send(D1, 8'h3f, 8'h00, 1'b0);
        send(D2, 8'hff, 8'h02, 1'b1);
        exp_q.push_back({1'b0, D0});
        exp_q.push_back({1'b0, D1});
        exp_q.push_back({1'b1, D2});
        finish_job("strb", base, 64'd22, 64'd0, 3'b010, 4);

        base = got_q.size();
        start_job(64'd1024);
        send(HDR_BAD, 8'hff, 8'h01, 1'b0);
        send(D3, 8'hff, 8'h00, 1'b0);
        send(D2, 8'hff, 8'h00, 1'b0);
        send(D1, 8'hff, 8'h02, 1'b0);
        send(HDR_DATA, 8'hff, 8'h01, 1'b0);
        send(D0, 8'hff, 8'h00, 1'b0);
        send(D1, 8'hff, 8'h02, 1'b1);
        exp_q.push_back({1'b0, D0});
        exp_q.push_back({1'b1, D1});
        finish_job("badtype", base, 64'd16, 64'd0, 3'b001, 5);

        start_job(64'd1024);
        send(HDR_DATA, 8'hff, 8'h01, 1'b0);
        send(D0, 8'hff, 8'h00, 1'b0);
        send(D1, 8'hff, 8'h00, 1'b0);
        @(negedge ap_clk);
        areset = 1'b1;
        @(posedge ap_clk);
        #1 areset = 1'b0;
        @(negedge ap_clk);
        check("mid_rst_size", output_data_size, 64'd0);
        check("mid_rst_tready", 64'(cceip_s_axis_tready), 64'd0);
        check("mid_rst_mm_valid", 64'(mm_m_axis_tvalid), 64'd0);
        check("mid_rst_mm_data", mm_m_axis_tdata, 64'd0);
        check("mid_rst_state", 64'(dut.state), 64'(s_idle));
        repeat (3) @(negedge ap_clk);
        check("mid_rst_no_done", 64'(done_cnt), 64'd5);

        base = got_q.size();
        std_job();
        finish_job("post_rst", base, 64'd28, 64'hDEAD_BEEF, 3'b000, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
